mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and write-back staging block between the EX/MEM pipeline register and the register-file write port. It consumes the EX/MEM register outputs, drives a variable-latency data memory over a req/ack handshake, and stalls the front of the pipeline while an access is outstanding. It then registers the selected write-back data into the WB stage.

## Interface
- TIMEOUT, 64: maximum cycles in WAIT before an access is abandoned; must be ≥2
- CNT_W, 16: width of the saturating stall-cycle counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- MEM_rf_wsel  in  2  write-back source select (WSEL_* encoding)
- MEM_rf_we  in  1  register-file write enable
- MEM_dram_we  in  1  store enable
- MEM_rD2  in  32  store data
- MEM_ext  in  32  immediate, for lui-type write-back
- MEM_pc4  in  32  return address
- MEM_alu_c  in  32  ALU result; also the memory address
- MEM_wR  in  32  destination register index; low 5 bits significant
- dram_req  out  1  memory request
- dram_we  out  1  request is a store
- dram_addr  out  32  = MEM_alu_c
- dram_wdata  out  32  = MEM_rD2
- dram_ack  in  1  request accepted and completed this cycle
- dram_rdata  in  32  load data, valid only with dram_ack
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- WB_rf_we  out  1  registered write enable
- WB_wR  out  5  registered destination index
- WB_wD  out  32  registered write data
- bus_err  out  1  sticky: an access timed out
- stall_cnt  out  CNT_W  total cycles with mem_stall=1, saturating

## Operation
- An access is a load (MEM_rf_we=1 and MEM_rf_wsel=WSEL_DRAM) or a store (MEM_dram_we=1). Everything else is a non-access. MEM_rf_we=0 and MEM_dram_we=0 together form a bubble.
- Write-data mux: WSEL_ALU→MEM_alu_c, WSEL_DRAM→dram_rdata, WSEL_PC4→MEM_pc4, WSEL_EXT→MEM_ext.
- FSM states are IDLE and WAIT.
- IDLE, non-access: dram_req=0 and mem_stall=0. WB registers load from the mux on the next edge.
- IDLE, access: dram_req=1 combinationally.
  - If dram_ack=1 in the same cycle (zero wait), mem_stall=0, WB loads and the state stays IDLE.
  - Otherwise mem_stall=1, the WB registers load a bubble (WB_rf_we=0), the state goes to WAIT and the timeout counter clears.
- WAIT: dram_req=1, mem_stall=1 and the WB registers load a bubble.
  - dram_addr, dram_wdata and dram_we stay stable because upstream is frozen by the stall.
  - On dram_ack: mem_stall=0 that cycle, WB loads (load data from dram_rdata), next state IDLE.
  - When the counter reaches TIMEOUT-1 with no ack: bus_err←1, mem_stall=0, dram_req=0, the WB registers load a bubble (the instruction is dropped), next state IDLE.
- dram_ack arriving while dram_req=0 is ignored.
- Stores never write the register file. A store's WB_rf_we equals MEM_rf_we, which the decoder keeps at 0 for stores.
- stall_cnt increments on every cycle with mem_stall=1 and holds at all-ones.
- bus_err clears only on rst.

## Timing
- Reset values: state IDLE, WB_rf_we=0, WB_wR=0, WB_wD=0, bus_err=0, stall_cnt=0, timeout counter=0.
- dram_req, mem_stall, dram_we, dram_addr and dram_wdata are combinational outputs.
- Reset is synchronous. Any rst=1 cycle, including mid-WAIT, returns to IDLE on that edge.
  - In the rst cycle, dram_req and mem_stall are forced 0.
  - An outstanding ack after reset is ignored. The memory model must tolerate the dropped request.
- Latency:
  - Non-access and zero-wait access: the MEM input appears on WB_* one edge later.
  - N-wait access (ack N cycles after the first request cycle): mem_stall is high for N cycles and WB_* updates on the edge that samples the ack.
- Back-to-back accesses: after an ack the next instruction enters IDLE on the following cycle. There is no dead cycle.
- Timeout: ack on cycle TIMEOUT-1 of WAIT completes normally, because ack wins over timeout in the same cycle.

## Structure
- The shared package holds the WSEL_ALU=0, WSEL_DRAM=1, WSEL_PC4=2, WSEL_EXT=3 constants and the 1-bit state encoding (ST_IDLE, ST_WAIT). These are shared with the decoder and the hazard unit.
- The stall counter goes in one sub-module, sat_counter (parameter W; inputs inc and clear; output count), reused by the other performance counters.
- The write-data mux and the FSM stay inline.

## Test plan
- **ALU write-back:** non-access, wsel=ALU, alu_c=0x0000_1234, wR=5 -> next edge WB_rf_we=1, WB_wR=5, WB_wD=0x1234; mem_stall never high.
- **Zero-wait load:** load at addr 0x40, ack in the same cycle, rdata=0xDEAD_BEEF -> no stall, WB_wD=0xDEADBEEF one edge later, stall_cnt=0.
- **3-wait store:** store addr 0x80, wdata=0x55, ack on the 4th request cycle -> mem_stall high for exactly 3 cycles, addr and wdata stable throughout, WB_rf_we=0 each cycle, stall_cnt=3.
- **Timeout:** TIMEOUT=8, load with no ack -> 7 stall cycles, bus_err=1 on the 8th edge, WB_rf_we=0, IDLE; a following ALU instruction writes back normally.
- **Reset mid-WAIT:** rst asserted on the 2nd wait cycle -> dram_req=0 and mem_stall=0 in that cycle, all outputs at reset values after the edge; a late ack is ignored.
- **Saturation:** CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage, the decoder and the hazard unit:
// write-back source select encoding and the memory-access FSM state encoding.
package mem_wb_stage_pkg;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_DRAM = 2'd1;
  localparam logic [1:0] WSEL_PC4  = 2'd2;
  localparam logic [1:0] WSEL_EXT  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // A load writes memory data back; a store drives a write request.
  function automatic logic is_access(input logic rf_we, input logic [1:0] rf_wsel,
                                     input logic dram_we);
    return (rf_we && (rf_wsel == WSEL_DRAM)) || dram_we;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_wb_stage_if;
  logic        dram_req;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;

  modport master (
    output dram_req, dram_we, dram_addr, dram_wdata,
    input  dram_ack, dram_rdata
  );

  modport slave (
    input  dram_req, dram_we, dram_addr, dram_wdata,
    output dram_ack, dram_rdata
  );
endinterface

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter shared by the performance counters; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: drives the variable-latency data memory, stalls the front of
// the pipeline while an access is outstanding, and registers write-back data.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 64,  // must be >= 2
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MEM_rf_wsel,
  input  logic              MEM_rf_we,
  input  logic              MEM_dram_we,
  input  logic [31:0]       MEM_rD2,
  input  logic [31:0]       MEM_ext,
  input  logic [31:0]       MEM_pc4,
  input  logic [31:0]       MEM_alu_c,
  input  logic [31:0]       MEM_wR,
  mem_wb_stage_if.master    dram,
  output logic              mem_stall,
  output logic              WB_rf_we,
  output logic [4:0]        WB_wR,
  output logic [31:0]       WB_wD,
  output logic              bus_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e         state, state_nxt;
  logic [TCW-1:0] tcnt;
  logic           access;
  logic           req;
  logic           stall;
  logic           wb_load;
  logic           tcnt_clr;
  logic           tcnt_inc;
  logic           err_set;
  logic [31:0]    wd_mux;
  logic           unused_wr_hi;

  assign unused_wr_hi = ^MEM_wR[31:5];

  assign access = is_access(MEM_rf_we, MEM_rf_wsel, MEM_dram_we);

  // Upstream is frozen while stalled, so these stay stable through WAIT.
  assign dram.dram_we    = MEM_dram_we;
  assign dram.dram_addr  = MEM_alu_c;
  assign dram.dram_wdata = MEM_rD2;
  assign dram.dram_req   = req;
  assign mem_stall       = stall;

  always_comb begin
    wd_mux = MEM_alu_c;
    case (MEM_rf_wsel)
      WSEL_ALU:  wd_mux = MEM_alu_c;
      WSEL_DRAM: wd_mux = dram.dram_rdata;
      WSEL_PC4:  wd_mux = MEM_pc4;
      WSEL_EXT:  wd_mux = MEM_ext;
      default:   wd_mux = MEM_alu_c;
    endcase
  end

  // tcnt holds the WAIT cycles already spent; the access is abandoned on the
  // (TIMEOUT-1)th WAIT cycle, i.e. the TIMEOUT-th request cycle. Ack wins.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    wb_load   = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (dram.dram_ack) begin
            wb_load = 1'b1;
          end else begin
            stall     = 1'b1;
            tcnt_clr  = 1'b1;
            state_nxt = ST_WAIT;
          end
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dram.dram_ack) begin
          wb_load   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tcnt == TCW'(TIMEOUT - 2)) begin
          req       = 1'b0;
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall    = 1'b1;
          tcnt_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      req       = 1'b0;
      stall     = 1'b0;
      wb_load   = 1'b0;
      err_set   = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || tcnt_clr)
      tcnt <= '0;
    else if (tcnt_inc)
      tcnt <= tcnt + TCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      bus_err <= 1'b0;
    else if (err_set)
      bus_err <= 1'b1;
  end

  // Bubbles only drop the write enable; index and data keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_rf_we <= 1'b0;
      WB_wR    <= '0;
      WB_wD    <= '0;
    end else if (wb_load) begin
      WB_rf_we <= MEM_rf_we;
      WB_wR    <= MEM_wR[4:0];
      WB_wD    <= wd_mux;
    end else begin
      WB_rf_we <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall),
    .clear (rst),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table vectors, directed multi-cycle
// sequences and a randomized run against a request-count reference model.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       MEM_rf_wsel;
  logic             MEM_rf_we, MEM_dram_we;
  logic [31:0]      MEM_rD2, MEM_ext, MEM_pc4, MEM_alu_c, MEM_wR;
  logic             mem_stall, WB_rf_we, bus_err;
  logic [4:0]       WB_wR;
  logic [31:0]      WB_wD;
  logic [CNT_W-1:0] stall_cnt;

  mem_wb_stage_if bus();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MEM_rf_wsel(MEM_rf_wsel), .MEM_rf_we(MEM_rf_we), .MEM_dram_we(MEM_dram_we),
    .MEM_rD2(MEM_rD2), .MEM_ext(MEM_ext), .MEM_pc4(MEM_pc4),
    .MEM_alu_c(MEM_alu_c), .MEM_wR(MEM_wR),
    .dram(bus),
    .mem_stall(mem_stall), .WB_rf_we(WB_rf_we), .WB_wR(WB_wR), .WB_wD(WB_wD),
    .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  wsel;
    logic        rf_we;
    logic        dwe;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [31:0] pc4;
    logic [31:0] wr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] wsel, input logic rf_we, input logic dwe,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [31:0] wr);
    MEM_rf_wsel = wsel; MEM_rf_we = rf_we; MEM_dram_we = dwe;
    MEM_alu_c = alu; MEM_rD2 = rd2; MEM_wR = wr;
    MEM_ext = 32'h0; MEM_pc4 = 32'h0;
  endtask

  task automatic cyc(input logic a, input logic [31:0] rd, input logic er,
                     input logic es, input string nm);
    bus.dram_ack = a; bus.dram_rdata = rd;
    #1;
    chk({nm, "_req"},   32'(bus.dram_req), 32'(er));
    chk({nm, "_stall"}, 32'(mem_stall),    32'(es));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr(WSEL_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.dram_ack = 1'b0; bus.dram_rdata = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] ref_mux(input logic [1:0] wsel, input logic [31:0] alu,
                                          input logic [31:0] rdata, input logic [31:0] pc4,
                                          input logic [31:0] ext);
    case (wsel)
      WSEL_DRAM: return rdata;
      WSEL_PC4:  return pc4;
      WSEL_EXT:  return ext;
      default:   return alu;
    endcase
  endfunction

  // reference-model state for the randomized run
  int          age, lat, kind;
  bit          frozen, r, acc, a;
  bit          e_req, e_stall, e_load, e_err;
  int          m_cnt;
  bit          m_err, m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  initial begin
    tbl[0] = '{WSEL_ALU,  1'b1, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 32'd5,
               1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd5,  32'h1234};
    tbl[1] = '{WSEL_DRAM, 1'b1, 1'b0, 32'h40,   32'h0, 32'h0, 32'h0, 32'd9,
               1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd9,  32'hDEADBEEF};
    tbl[2] = '{WSEL_PC4,  1'b1, 1'b0, 32'h999,  32'h0, 32'h0, 32'h1004, 32'd31,
               1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 5'd31, 32'h1004};
    tbl[3] = '{WSEL_EXT,  1'b1, 1'b0, 32'h5,    32'h0, 32'hABCD0000, 32'h8, 32'd1,
               1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd1,  32'hABCD0000};
    tbl[4] = '{WSEL_ALU,  1'b0, 1'b1, 32'h44,   32'h77, 32'h0, 32'h0, 32'd2,
               1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[5] = '{WSEL_DRAM, 1'b0, 1'b0, 32'h0,    32'h0, 32'h0, 32'h0, 32'd6,
               1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[6] = '{WSEL_ALU,  1'b1, 1'b0, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0, 32'hFFFFFFE3,
               1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd3,  32'h0F0F0F0F};

    // reset: a pending load during rst must not raise req or stall
    rst = 1'b1;
    instr(WSEL_DRAM, 1'b1, 1'b0, 32'h40, 32'h0, 32'd7);
    bus.dram_ack = 1'b0; bus.dram_rdata = 32'h0;
    #1;
    chk("rst_req",   32'(bus.dram_req), 32'h0);
    chk("rst_stall", 32'(mem_stall),    32'h0);
    tick();
    tick();
    chk("rst_wb_we",  32'(WB_rf_we),  32'h0);
    chk("rst_wb_wr",  32'(WB_wR),     32'h0);
    chk("rst_wb_wd",  WB_wD,          32'h0);
    chk("rst_bus_err", 32'(bus_err),  32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b0;

    // single-cycle vectors: non-access and zero-wait accesses
    for (int i = 0; i < 7; i++) begin
      MEM_rf_wsel = tbl[i].wsel; MEM_rf_we = tbl[i].rf_we; MEM_dram_we = tbl[i].dwe;
      MEM_alu_c = tbl[i].alu; MEM_rD2 = tbl[i].rd2; MEM_ext = tbl[i].ext;
      MEM_pc4 = tbl[i].pc4; MEM_wR = tbl[i].wr;
      bus.dram_ack = tbl[i].ack; bus.dram_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d_req", i),   32'(bus.dram_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_stall", i), 32'(mem_stall),    32'(tbl[i].e_stall));
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_addr", i),  bus.dram_addr,  tbl[i].alu);
        chk($sformatf("vec%0d_wdata", i), bus.dram_wdata, tbl[i].rd2);
        chk($sformatf("vec%0d_dwe", i),   32'(bus.dram_we), 32'(tbl[i].dwe));
      end
      tick();
      chk($sformatf("vec%0d_wb_we", i), 32'(WB_rf_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_wb_wr", i), 32'(WB_wR), 32'(tbl[i].e_wr));
        chk($sformatf("vec%0d_wb_wd", i), WB_wD, tbl[i].e_wd);
      end
    end
    chk("zero_wait_stall_cnt", 32'(stall_cnt), 32'h0);

    // 3-wait store, then 2-wait load, then back-to-back ALU
    do_reset();
    instr(WSEL_ALU, 1'b0, 1'b1, 32'h80, 32'h55, 32'd3);
    for (int k = 0; k < 3; k++) begin
      bus.dram_ack = 1'b0;
      #1;
      chk("st3_addr",  bus.dram_addr,  32'h80);
      chk("st3_wdata", bus.dram_wdata, 32'h55);
      chk("st3_dwe",   32'(bus.dram_we), 32'h1);
      chk("st3_req",   32'(bus.dram_req), 32'h1);
      chk("st3_stall", 32'(mem_stall), 32'h1);
      tick();
      chk("st3_wb_we", 32'(WB_rf_we), 32'h0);
    end
    cyc(1'b1, 32'h0, 1'b1, 1'b0, "st3_ack");
    chk("st3_wb_we_end", 32'(WB_rf_we), 32'h0);
    chk("st3_stall_cnt", 32'(stall_cnt), 32'd3);

    instr(WSEL_DRAM, 1'b1, 1'b0, 32'h90, 32'h0, 32'd7);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, "ld2_w1");
    cyc(1'b0, 32'h0, 1'b1, 1'b1, "ld2_w2");
    cyc(1'b1, 32'hCAFE0001, 1'b1, 1'b0, "ld2_ack");
    chk("ld2_wb_we", 32'(WB_rf_we), 32'h1);
    chk("ld2_wb_wr", 32'(WB_wR), 32'd7);
    chk("ld2_wb_wd", WB_wD, 32'hCAFE0001);
    instr(WSEL_ALU, 1'b1, 1'b0, 32'h3333, 32'h0, 32'd8);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "b2b_alu");
    chk("b2b_wb_wd", WB_wD, 32'h3333);
    chk("b2b_stall_cnt", 32'(stall_cnt), 32'd5);

    // timeout: 7 stall cycles, bus_err on the 8th edge
    do_reset();
    instr(WSEL_DRAM, 1'b1, 1'b0, 32'hA0, 32'h0, 32'd9);
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1, "to_wait");
      chk("to_no_err_yet", 32'(bus_err), 32'h0);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "to_fire");
    chk("to_bus_err", 32'(bus_err), 32'h1);
    chk("to_wb_we",   32'(WB_rf_we), 32'h0);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd7);
    instr(WSEL_ALU, 1'b1, 1'b0, 32'h2222, 32'h0, 32'd4);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "to_next_alu");
    chk("to_next_wb_we", 32'(WB_rf_we), 32'h1);
    chk("to_next_wb_wd", WB_wD, 32'h2222);
    chk("to_err_sticky", 32'(bus_err), 32'h1);

    // ack on the last allowed WAIT cycle still completes
    do_reset();
    instr(WSEL_DRAM, 1'b1, 1'b0, 32'hB0, 32'h0, 32'd10);
    for (int k = 0; k < TIMEOUT - 1; k++) cyc(1'b0, 32'h0, 1'b1, 1'b1, "late_wait");
    cyc(1'b1, 32'h600D, 1'b1, 1'b0, "late_ack");
    chk("late_bus_err", 32'(bus_err), 32'h0);
    chk("late_wb_wd", WB_wD, 32'h600D);

    // reset mid-WAIT, then a late ack is ignored
    do_reset();
    instr(WSEL_DRAM, 1'b1, 1'b0, 32'hC0, 32'h0, 32'd11);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, "rw_w1");
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "rw_rst");
    rst = 1'b0;
    chk("rw_wb_we",  32'(WB_rf_we), 32'h0);
    chk("rw_wb_wr",  32'(WB_wR), 32'h0);
    chk("rw_wb_wd",  WB_wD, 32'h0);
    chk("rw_stall_cnt", 32'(stall_cnt), 32'h0);
    instr(WSEL_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    cyc(1'b1, 32'hBAD, 1'b0, 1'b0, "rw_late_ack");
    chk("rw_late_wb_we", 32'(WB_rf_we), 32'h0);
    chk("rw_late_err", 32'(bus_err), 32'h0);
    chk("rw_late_stall_cnt", 32'(stall_cnt), 32'h0);

    // saturation: 7 + 7 + 6 = 20 stall cycles with a 4-bit counter
    do_reset();
    for (int t = 0; t < 2; t++) begin
      instr(WSEL_DRAM, 1'b1, 1'b0, 32'hD0, 32'h0, 32'd12);
      for (int k = 0; k < TIMEOUT - 1; k++) cyc(1'b0, 32'h0, 1'b1, 1'b1, "sat_wait");
      cyc(1'b0, 32'h0, 1'b0, 1'b0, "sat_to");
    end
    chk("sat_cnt14", 32'(stall_cnt), 32'd14);
    instr(WSEL_DRAM, 1'b1, 1'b0, 32'hD4, 32'h0, 32'd13);
    for (int k = 0; k < 6; k++) cyc(1'b0, 32'h0, 1'b1, 1'b1, "sat_w");
    cyc(1'b1, 32'h1, 1'b1, 1'b0, "sat_ack");
    chk("sat_cnt15", 32'(stall_cnt), 32'd15);

    // randomized run against the request-count model
    do_reset();
    age = 0; frozen = 0; kind = 0; lat = 0;
    m_cnt = 0; m_err = 0; m_we = 0; m_wr = '0; m_wd = '0;
    for (int c = 0; c < 600; c++) begin
      if (!frozen) begin
        kind = $urandom_range(0, 5);
        MEM_alu_c = $urandom; MEM_rD2 = $urandom; MEM_ext = $urandom;
        MEM_pc4 = $urandom; MEM_wR = $urandom;
        case (kind)
          0: begin MEM_rf_wsel = WSEL_ALU;  MEM_rf_we = 1'b1; MEM_dram_we = 1'b0; end
          1: begin MEM_rf_wsel = WSEL_PC4;  MEM_rf_we = 1'b1; MEM_dram_we = 1'b0; end
          2: begin MEM_rf_wsel = WSEL_EXT;  MEM_rf_we = 1'b1; MEM_dram_we = 1'b0; end
          3: begin MEM_rf_wsel = WSEL_DRAM; MEM_rf_we = 1'b1; MEM_dram_we = 1'b0; end
          4: begin MEM_rf_wsel = 2'($urandom_range(0, 3)); MEM_rf_we = 1'b0; MEM_dram_we = 1'b1; end
          default: begin MEM_rf_wsel = 2'($urandom_range(0, 3)); MEM_rf_we = 1'b0; MEM_dram_we = 1'b0; end
        endcase
        lat = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, TIMEOUT - 1);
      end
      acc = (kind == 3) || (kind == 4);
      r   = ($urandom_range(0, 49) == 0);
      a   = acc ? (age == lat) : ($urandom_range(0, 2) == 0);
      if (r) a = ($urandom_range(0, 1) == 1);
      rst = r;
      bus.dram_ack = a; bus.dram_rdata = $urandom;

      // expected behaviour from the request index of the current access
      e_req = 0; e_stall = 0; e_load = 0; e_err = 0;
      if (r) begin
      end else if (acc) begin
        if (a) begin e_req = 1; e_load = 1; end
        else if (age + 1 == TIMEOUT) e_err = 1;
        else begin e_req = 1; e_stall = 1; end
      end else begin
        e_load = 1;
      end
      #1;
      chk("rnd_req",   32'(bus.dram_req), 32'(e_req));
      chk("rnd_stall", 32'(mem_stall),    32'(e_stall));
      if (e_req) chk("rnd_addr", bus.dram_addr, MEM_alu_c);

      if (r) begin
        m_cnt = 0; m_err = 0; m_we = 0; m_wr = '0; m_wd = '0;
      end else begin
        if (e_stall && m_cnt < CNT_MAX) m_cnt++;
        if (e_err) m_err = 1;
        if (e_load) begin
          m_we = MEM_rf_we; m_wr = MEM_wR[4:0];
          m_wd = ref_mux(MEM_rf_wsel, MEM_alu_c, bus.dram_rdata, MEM_pc4, MEM_ext);
        end else begin
          m_we = 0;
        end
      end
      tick();
      chk("rnd_wb_we",     32'(WB_rf_we),  32'(m_we));
      chk("rnd_bus_err",   32'(bus_err),   32'(m_err));
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (m_we) begin
        chk("rnd_wb_wr", 32'(WB_wR), 32'(m_wr));
        chk("rnd_wb_wd", WB_wD, m_wd);
      end
      frozen = !r && e_stall;
      age    = frozen ? age + 1 : 0;
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
